// File: rtl/m_ext_ctrl.sv
// RV32M execute front-end: routes one M-extension instruction to the multiplier or
// divider, resolves divide special cases locally and holds the registered result for writeback.
module m_ext_ctrl #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic [4:0]      rd_i,
    output logic            mul_in_valid_o,
    input  logic            mul_in_ready_i,
    output logic [XLEN-1:0] mul_a_o,
    output logic [XLEN-1:0] mul_b_o,
    output logic [1:0]      mul_op_o,
    input  logic            mul_out_valid_i,
    output logic            mul_out_ready_o,
    input  logic [XLEN-1:0] mul_res_i,
    output logic            div_in_valid_o,
    input  logic            div_in_ready_i,
    output logic [XLEN-1:0] div_a_o,
    output logic [XLEN-1:0] div_b_o,
    output logic [1:0]      div_op_o,
    input  logic            div_out_valid_i,
    output logic            div_out_ready_o,
    input  logic [XLEN-1:0] div_res_i,
    output logic            wb_valid_o,
    input  logic            wb_ready_i,
    output logic [4:0]      wb_rd_o,
    output logic [XLEN-1:0] wb_data_o,
    output logic            busy_o
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    typedef struct packed {
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [2:0]      f3;
        logic [4:0]      rd;
    } req_t;

    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    state_t          state, state_nxt;
    req_t            req_q, req_nxt;
    logic [XLEN-1:0] res_q, res_nxt;
    logic            is_div, is_rem, is_uns, div_zero, div_ovf;

    // Special cases are decided on the operands being captured this cycle,
    // so the short path reaches RESP without touching the divider.
    assign is_div   = funct3_i[2];
    assign is_rem   = funct3_i[1];
    assign is_uns   = funct3_i[0];
    assign div_zero = (rs2_i == '0);
    assign div_ovf  = !is_uns && (rs1_i == INT_MIN) && (rs2_i == '1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            req_q <= '0;
            res_q <= '0;
        end else begin
            state <= state_nxt;
            req_q <= req_nxt;
            res_q <= res_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        req_nxt         = req_q;
        res_nxt         = res_q;
        in_ready_o      = 1'b0;
        mul_in_valid_o  = 1'b0;
        mul_out_ready_o = 1'b0;
        div_in_valid_o  = 1'b0;
        div_out_ready_o = 1'b0;
        wb_valid_o      = 1'b0;
        case (state)
            IDLE: begin
                in_ready_o = 1'b1;
                if (in_valid_i) begin
                    req_nxt = '{a: rs1_i, b: rs2_i, f3: funct3_i, rd: rd_i};
                    if (is_div && div_zero) begin
                        res_nxt   = is_rem ? rs1_i : '1;
                        state_nxt = RESP;
                    end else if (is_div && div_ovf) begin
                        res_nxt   = is_rem ? '0 : INT_MIN;
                        state_nxt = RESP;
                    end else begin
                        state_nxt = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (req_q.f3[2]) begin
                    div_in_valid_o = 1'b1;
                    if (div_in_ready_i) state_nxt = WAIT;
                end else begin
                    mul_in_valid_o = 1'b1;
                    if (mul_in_ready_i) state_nxt = WAIT;
                end
            end
            WAIT: begin
                // Only the selected unit's result is taken; the other unit is ignored.
                if (req_q.f3[2]) begin
                    div_out_ready_o = 1'b1;
                    if (div_out_valid_i) begin
                        res_nxt   = div_res_i;
                        state_nxt = RESP;
                    end
                end else begin
                    mul_out_ready_o = 1'b1;
                    if (mul_out_valid_i) begin
                        res_nxt   = mul_res_i;
                        state_nxt = RESP;
                    end
                end
            end
            RESP: begin
                wb_valid_o = 1'b1;
                if (wb_ready_i) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign mul_a_o   = req_q.a;
    assign mul_b_o   = req_q.b;
    assign mul_op_o  = req_q.f3[1:0];
    assign div_a_o   = req_q.a;
    assign div_b_o   = req_q.b;
    assign div_op_o  = req_q.f3[1:0];
    assign wb_rd_o   = req_q.rd;
    assign wb_data_o = res_q;
    assign busy_o    = (state != IDLE);

endmodule

// File: tb/tb_m_ext_ctrl.sv
// Directed bench for m_ext_ctrl: an arithmetic RV32M model predicts every writeback,
// a per-cycle compare process checks issue and writeback against it.
module tb_m_ext_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [2:0]  funct3_i;
    logic [31:0] rs1_i, rs2_i;
    logic [4:0]  rd_i;
    logic        mul_in_valid_o, mul_in_ready_i;
    logic [31:0] mul_a_o, mul_b_o;
    logic [1:0]  mul_op_o;
    logic        mul_out_valid_i, mul_out_ready_o;
    logic [31:0] mul_res_i;
    logic        div_in_valid_o, div_in_ready_i;
    logic [31:0] div_a_o, div_b_o;
    logic [1:0]  div_op_o;
    logic        div_out_valid_i, div_out_ready_o;
    logic [31:0] div_res_i;
    logic        wb_valid_o, wb_ready_i;
    logic [4:0]  wb_rd_o;
    logic [31:0] wb_data_o;
    logic        busy_o;

    m_ext_ctrl #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .funct3_i(funct3_i),
        .rs1_i(rs1_i), .rs2_i(rs2_i), .rd_i(rd_i),
        .mul_in_valid_o(mul_in_valid_o), .mul_in_ready_i(mul_in_ready_i),
        .mul_a_o(mul_a_o), .mul_b_o(mul_b_o), .mul_op_o(mul_op_o),
        .mul_out_valid_i(mul_out_valid_i), .mul_out_ready_o(mul_out_ready_o), .mul_res_i(mul_res_i),
        .div_in_valid_o(div_in_valid_o), .div_in_ready_i(div_in_ready_i),
        .div_a_o(div_a_o), .div_b_o(div_b_o), .div_op_o(div_op_o),
        .div_out_valid_i(div_out_valid_i), .div_out_ready_o(div_out_ready_o), .div_res_i(div_res_i),
        .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i), .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o),
        .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [36:0] exp_q[$];  // {rd, data}
    logic [2:0]  cur_f3;
    logic [31:0] cur_a, cur_b;
    logic        cur_sp;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference RV32M semantics, computed with 64-bit arithmetic.
    function automatic logic [31:0] model_res(input logic [2:0] f3, input logic [31:0] a,
                                              input logic [31:0] b);
        longint          sa, sb;
        longint unsigned ua, ub, p;
        sa = $signed(a);
        sb = $signed(b);
        ua = a;
        ub = b;
        p  = 0;
        case (f3)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                p = sa / sb; return p[31:0];
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                p = ua / ub; return p[31:0];
            end
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                p = sa % sb; return p[31:0];
            end
            default: begin
                if (b == 0) return a;
                p = ua % ub; return p[31:0];
            end
        endcase
    endfunction

    function automatic logic model_special(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] b);
        return f3[2] && ((b == 0) || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    endfunction

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        if (rst_n) begin
            if (mul_in_valid_o) begin
                chk("mul_sel", {62'd0, cur_f3[2], cur_sp}, 64'd0);
                chk("mul_a", mul_a_o, cur_a);
                chk("mul_b", mul_b_o, cur_b);
                chk("mul_op", mul_op_o, cur_f3[1:0]);
            end
            if (div_in_valid_o) begin
                chk("div_sel", {62'd0, cur_f3[2], cur_sp}, 64'd2);
                chk("div_a", div_a_o, cur_a);
                chk("div_b", div_b_o, cur_b);
                chk("div_op", div_op_o, cur_f3[1:0]);
            end
            if (wb_valid_o) begin
                if (exp_q.size() == 0) begin
                    chk("wb_unexpected", 64'd1, 64'd0);
                end else begin
                    chk("wb_rd", wb_rd_o, exp_q[0][36:32]);
                    chk("wb_data", wb_data_o, exp_q[0][31:0]);
                    chk("wb_inready", in_ready_o, 1'b0);
                    if (wb_ready_i) void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset();
        chk("rst_ctl", {48'd0, in_ready_o, mul_in_valid_o, mul_out_ready_o, div_in_valid_o,
                        div_out_ready_o, wb_valid_o, busy_o, mul_op_o, div_op_o, wb_rd_o},
            64'h8000);
        chk("rst_mul_a", mul_a_o, 0);
        chk("rst_mul_b", mul_b_o, 0);
        chk("rst_div_a", div_a_o, 0);
        chk("rst_div_b", div_b_o, 0);
        chk("rst_wb_data", wb_data_o, 0);
    endtask

    // One instruction end to end; poke raises a competing in_valid during writeback stall.
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input int in_lat, input int out_lat,
                          input int wb_stall, input logic poke);
        int n;
        cur_f3 = f3; cur_a = a; cur_b = b;
        cur_sp = model_special(f3, a, b);
        exp_q.push_back({rd, model_res(f3, a, b)});
        in_valid_i = 1'b1; funct3_i = f3; rs1_i = a; rs2_i = b; rd_i = rd;
        n = 0;
        while (!in_ready_o && n < 20) begin tick(); n++; end
        chk("accept_ready", in_ready_o, 1'b1);
        tick();
        in_valid_i = 1'b0;
        rs1_i = '0; rs2_i = '0; funct3_i = '0; rd_i = '0;
        if (cur_sp) begin
            chk("sp_latency", wb_valid_o, 1'b1);
            chk("sp_no_div", {div_in_valid_o, div_out_ready_o}, 2'b00);
        end else begin
            for (int i = 0; i < in_lat; i++) begin
                chk("issue_hold", {mul_in_valid_o, div_in_valid_o}, f3[2] ? 2'b01 : 2'b10);
                tick();
            end
            chk("issue_valid", {mul_in_valid_o, div_in_valid_o}, f3[2] ? 2'b01 : 2'b10);
            if (f3[2]) div_in_ready_i = 1'b1; else mul_in_ready_i = 1'b1;
            tick();
            div_in_ready_i = 1'b0; mul_in_ready_i = 1'b0;
            // Unselected unit flags a result while waiting; it must be ignored.
            for (int i = 0; i < out_lat; i++) begin
                chk("wait_ready", {mul_out_ready_o, div_out_ready_o}, f3[2] ? 2'b01 : 2'b10);
                if (f3[2]) begin mul_out_valid_i = 1'b1; mul_res_i = 32'hDEAD_BEEF; end
                else begin div_out_valid_i = 1'b1; div_res_i = 32'hDEAD_BEEF; end
                tick();
                mul_out_valid_i = 1'b0; div_out_valid_i = 1'b0;
                chk("wait_no_wb", wb_valid_o, 1'b0);
            end
            chk("wait_ready", {mul_out_ready_o, div_out_ready_o}, f3[2] ? 2'b01 : 2'b10);
            if (f3[2]) begin div_out_valid_i = 1'b1; div_res_i = model_res(f3, a, b); end
            else begin mul_out_valid_i = 1'b1; mul_res_i = model_res(f3, a, b); end
            tick();
            mul_out_valid_i = 1'b0; div_out_valid_i = 1'b0;
            mul_res_i = '0; div_res_i = '0;
            chk("res_latency", wb_valid_o, 1'b1);
        end
        for (int i = 0; i < wb_stall; i++) begin
            if (poke) begin
                in_valid_i = 1'b1; funct3_i = 3'd0; rs1_i = 32'd1; rs2_i = 32'd1; rd_i = 5'd9;
            end
            tick();
            chk("stall_hold", {wb_valid_o, in_ready_o, busy_o}, 3'b101);
        end
        in_valid_i = 1'b0;
        wb_ready_i = 1'b1;
        tick();
        wb_ready_i = 1'b0;
        chk("back_idle", {wb_valid_o, in_ready_o, busy_o}, 3'b010);
        chk("model_drained", exp_q.size(), 0);
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid_i = 0; funct3_i = 0; rs1_i = 0; rs2_i = 0; rd_i = 0;
        mul_in_ready_i = 0; mul_out_valid_i = 0; mul_res_i = 0;
        div_in_ready_i = 0; div_out_valid_i = 0; div_res_i = 0;
        wb_ready_i = 0;
        cur_f3 = 0; cur_a = 0; cur_b = 0; cur_sp = 0;

        // Hand-computed anchors for the model itself.
        chk("pin_mul", model_res(3'd0, 32'd7, 32'd6), 32'h0000_002A);
        chk("pin_mulhu", model_res(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFE);
        chk("pin_divu0", model_res(3'd5, 32'd100, 32'd0), 32'hFFFF_FFFF);
        chk("pin_rem0", model_res(3'd6, 32'd100, 32'd0), 32'h0000_0064);
        chk("pin_div_ovf", model_res(3'd4, 32'h8000_0000, 32'hFFFF_FFFF), 32'h8000_0000);
        chk("pin_rem_ovf", model_res(3'd6, 32'h8000_0000, 32'hFFFF_FFFF), 32'h0);
        chk("pin_divu", model_res(3'd5, 32'd20, 32'd3), 32'd6);
        chk("pin_div_neg", model_res(3'd4, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFD);
        chk("pin_rem_neg", model_res(3'd6, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);

        tick(); tick();
        check_reset();
        rst_n = 1'b1;
        tick();
        check_reset();

        run_op(3'd0, 32'd7, 32'd6, 5'd5, 0, 2, 0, 0);                          // MUL
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 3, 1, 0, 0);          // MULHU stalled
        run_op(3'd5, 32'd100, 32'd0, 5'd3, 0, 0, 0, 0);                        // DIVU /0
        run_op(3'd6, 32'd100, 32'd0, 5'd4, 0, 0, 1, 0);                        // REM /0
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 0, 0, 0, 0);         // DIV ovf
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 0, 0, 0, 0);         // REM ovf
        run_op(3'd5, 32'd20, 32'd3, 5'd12, 1, 2, 4, 1);                        // DIVU backpressure
        run_op(3'd1, 32'hFFFF_FFFD, 32'd5, 5'd0, 0, 0, 0, 0);                  // MULH, rd=0
        run_op(3'd2, 32'hFFFF_FFFF, 32'd2, 5'd13, 1, 0, 0, 0);                 // MULHSU
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd14, 0, 1, 0, 0);                 // DIV negative
        run_op(3'd7, 32'd23, 32'd5, 5'd15, 2, 0, 1, 0);                        // REMU

        // Reset while waiting on the multiplier.
        cur_f3 = 3'd0; cur_a = 32'd5; cur_b = 32'd5; cur_sp = 1'b0;
        in_valid_i = 1'b1; funct3_i = 3'd0; rs1_i = 32'd5; rs2_i = 32'd5; rd_i = 5'd20;
        tick();
        in_valid_i = 1'b0;
        mul_in_ready_i = 1'b1;
        tick();
        mul_in_ready_i = 1'b0;
        chk("pre_rst_wait", {mul_out_ready_o, busy_o}, 2'b11);
        #2 rst_n = 1'b0;
        #1 check_reset();
        exp_q.delete();
        tick();
        rst_n = 1'b1;
        mul_out_valid_i = 1'b1; mul_res_i = 32'd25;
        tick();
        mul_out_valid_i = 1'b0; mul_res_i = '0;
        chk("late_valid_ignored", {wb_valid_o, busy_o, in_ready_o}, 3'b001);
        run_op(3'd0, 32'd3, 32'd3, 5'd21, 0, 1, 0, 0);                         // MUL after reset

        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
